write_buffer: RTL and testbench

//   Single-entry posted-write buffer: the responder for the data cache's buffer_* write/flush port.

---
 rtl/write_buffer.sv | 100 ++++++++++
 tb/tb_write_buffer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_buffer.sv
// Single-entry posted-write buffer: latches one byte/half/word store and drains it bytewise to memory.
// Optional macro WBUF_IO_STALL_EN adds the io_full port that pauses draining of IO-space stores.
module write_buffer #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              buffer_write,
   input  logic [2:0]        buffer_length,
   input  logic [ADDR_W-1:0] buffer_addr,
   input  logic [DATA_W-1:0] buffer_data,
   output logic              buffer_busy,
   output logic              mem_req,
   input  logic              mem_grant,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_dout
`ifdef WBUF_IO_STALL_EN
   ,
   input  logic              io_full
`endif
);

   typedef enum logic {
      IDLE,
      DRAIN
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [1:0]        last_q, last_d;
   logic [1:0]        k_q, k_d;
   logic              io_stall;

`ifdef WBUF_IO_STALL_EN
   assign io_stall = base_q[ADDR_W-1] && io_full;
`else
   assign io_stall = 1'b0;
`endif

   // The beat address and byte come straight from the entry, so they hold whenever k holds.
   assign mem_addr = base_q + {{(ADDR_W-2){1'b0}}, k_q};
   assign mem_dout = data_q[{k_q, 3'b000} +: 8];

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      data_d      = data_q;
      last_d      = last_q;
      k_d         = k_q;
      mem_req     = (state_q == DRAIN) && !io_stall;
      buffer_busy = (state_q != IDLE) || buffer_write;
      case (state_q)
         IDLE: begin
            if (buffer_write) begin
               base_d  = buffer_addr;
               data_d  = buffer_data;
               k_d     = 2'd0;
               state_d = DRAIN;
               if (buffer_length[0]) begin
                  last_d = 2'd0;
               end else if (buffer_length[1]) begin
                  last_d = 2'd1;
               end else begin
                  last_d = 2'd3;
               end
            end
         end
         DRAIN: begin
            // A store arriving here is a cache protocol error and is deliberately dropped.
            if (mem_req && mem_grant) begin
               if (k_q == last_q) begin
                  state_d = IDLE;
               end else begin
                  k_d = k_q + 2'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         base_q  <= '0;
         data_q  <= '0;
         last_q  <= 2'd0;
         k_q     <= 2'd0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         data_q  <= data_d;
         last_q  <= last_d;
         k_q     <= k_d;
      end
   end

endmodule

// File: tb/tb_write_buffer.sv
// Scoreboard bench for write_buffer: expected byte beats are queued when a store is issued
// and popped as the buffer presents granted beats on the memory port.
module tb_write_buffer;

   localparam int ADDR_W = 18;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } beat_t;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              buffer_write = 1'b0;
   logic [2:0]        buffer_length = 3'd0;
   logic [ADDR_W-1:0] buffer_addr = '0;
   logic [31:0]       buffer_data = '0;
   logic              buffer_busy;
   logic              mem_req;
   logic              mem_grant = 1'b0;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_dout;
   logic              io_full = 1'b0;

   beat_t exp_q[$];
   int    checks = 0;
   int    failures = 0;

   write_buffer #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
      .clock         (clock),
      .reset         (reset),
      .buffer_write  (buffer_write),
      .buffer_length (buffer_length),
      .buffer_addr   (buffer_addr),
      .buffer_data   (buffer_data),
      .buffer_busy   (buffer_busy),
      .mem_req       (mem_req),
      .mem_grant     (mem_grant),
      .mem_addr      (mem_addr),
      .mem_dout      (mem_dout)
`ifdef WBUF_IO_STALL_EN
      ,
      .io_full       (io_full)
`endif
   );

   always #5 clock = ~clock;

   task automatic push_beats(input logic [ADDR_W-1:0] a, input logic [31:0] d, input int n);
      beat_t t;
      for (int b = 0; b < n; b++) begin
         t.addr = a + ADDR_W'(b);
         t.data = d[8*b +: 8];
         exp_q.push_back(t);
      end
   endtask

   task automatic drive_store(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [2:0] len);
      buffer_write  = 1'b1;
      buffer_length = len;
      buffer_addr   = a;
      buffer_data   = d;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checks++; if (buffer_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", buffer_busy); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req: got %b expected 0", mem_req); end
      checks++; if (mem_addr !== '0) begin failures++; $display("[TB] FAIL reset_addr: got %h expected 0", mem_addr); end
      checks++; if (mem_dout !== 8'h00) begin failures++; $display("[TB] FAIL reset_dout: got %h expected 0", mem_dout); end
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      int busy_cycles = 0;
      drive_store(a, d, 3'd4);
      mem_grant = 1'b1;
      push_beats(a, d, 4);
      for (int i = 0; i < 7; i++) begin
         @(negedge clock);
         if (buffer_busy) busy_cycles++;
         checks++;
         if (mem_req !== 1'((i >= 1) && (i <= 4))) begin
            failures++; $display("[TB] FAIL word_req cycle %0d: got %b expected %b", i, mem_req, (i >= 1) && (i <= 4));
         end
         if (mem_req && mem_grant) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("[TB] FAIL word_extra_beat: got %h@%h expected none", mem_dout, mem_addr);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               if ({mem_addr, mem_dout} !== {e.addr, e.data}) begin
                  failures++; $display("[TB] FAIL word_beat: got %h@%h expected %h@%h", mem_dout, mem_addr, e.data, e.addr);
               end
            end
         end
         @(posedge clock); #1;
         buffer_write = 1'b0;
      end
      checks++; if (busy_cycles != 5) begin failures++; $display("[TB] FAIL word_busy_len: got %0d expected 5", busy_cycles); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL word_missing: got %0d left expected 0", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_half;
      int beats = 0;
      drive_store(18'h00202, 32'h0000_1234, 3'd2);
      mem_grant = 1'b0;
      push_beats(18'h00202, 32'h0000_1234, 2);
      for (int i = 0; i < 7; i++) begin
         @(negedge clock);
         checks++;
         if (mem_req !== 1'((i >= 1) && (i <= 4))) begin
            failures++; $display("[TB] FAIL half_req cycle %0d: got %b expected %b", i, mem_req, (i >= 1) && (i <= 4));
         end
         if (mem_req && !mem_grant && exp_q.size() != 0) begin
            checks++;
            if ({mem_addr, mem_dout} !== {exp_q[0].addr, exp_q[0].data}) begin
               failures++; $display("[TB] FAIL half_hold: got %h@%h expected %h@%h", mem_dout, mem_addr, exp_q[0].data, exp_q[0].addr);
            end
         end
         if (mem_req && mem_grant) begin
            beats++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("[TB] FAIL half_extra_beat: got %h@%h expected none", mem_dout, mem_addr);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               if ({mem_addr, mem_dout} !== {e.addr, e.data}) begin
                  failures++; $display("[TB] FAIL half_beat: got %h@%h expected %h@%h", mem_dout, mem_addr, e.data, e.addr);
               end
            end
         end
         @(posedge clock); #1;
         buffer_write = 1'b0;
         mem_grant = ((i + 1) >= 2) && ((i + 1) % 2 == 0);
      end
      checks++; if (beats != 2) begin failures++; $display("[TB] FAIL half_count: got %0d expected 2", beats); end
      exp_q.delete();
   endtask

   task automatic test_io;
      int first_beat = -1;
      int want_beat;
`ifdef WBUF_IO_STALL_EN
      want_beat = 6;
`else
      want_beat = 1;
`endif
      drive_store(18'h30000, 32'h0000_0041, 3'd1);
      mem_grant = 1'b1;
      io_full = 1'b1;
      push_beats(18'h30000, 32'h0000_0041, 1);
      for (int i = 0; i < 9; i++) begin
         @(negedge clock);
         if (mem_req && mem_grant) begin
            if (first_beat < 0) first_beat = i;
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("[TB] FAIL io_extra_beat: got %h@%h expected none", mem_dout, mem_addr);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               if ({mem_addr, mem_dout} !== {e.addr, e.data}) begin
                  failures++; $display("[TB] FAIL io_beat: got %h@%h expected %h@%h", mem_dout, mem_addr, e.data, e.addr);
               end
            end
         end
         @(posedge clock); #1;
         buffer_write = 1'b0;
         io_full = ((i + 1) < 6);
      end
      checks++; if (first_beat != want_beat) begin failures++; $display("[TB] FAIL io_stall_cycle: got %0d expected %0d", first_beat, want_beat); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL io_missing: got %0d left expected 0", exp_q.size()); end
      io_full = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset_mid;
      int beats = 0;
      drive_store(18'h00400, 32'h8765_4321, 3'd4);
      mem_grant = 1'b1;
      push_beats(18'h00400, 32'h8765_4321, 2);
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (i == 4) begin
            checks++; if (buffer_busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy: got %b expected 0", buffer_busy); end
            checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_req: got %b expected 0", mem_req); end
            checks++; if (mem_addr !== '0) begin failures++; $display("[TB] FAIL rstmid_addr: got %h expected 0", mem_addr); end
         end
         if (mem_req && mem_grant && !reset) begin
            beats++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("[TB] FAIL rstmid_extra_beat: got %h@%h expected none", mem_dout, mem_addr);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               if ({mem_addr, mem_dout} !== {e.addr, e.data}) begin
                  failures++; $display("[TB] FAIL rstmid_beat: got %h@%h expected %h@%h", mem_dout, mem_addr, e.data, e.addr);
               end
            end
         end
         @(posedge clock); #1;
         buffer_write = 1'b0;
         reset = ((i + 1) == 3);
         mem_grant = ((i + 1) != 3);
      end
      checks++; if (beats != 2) begin failures++; $display("[TB] FAIL rstmid_count: got %0d expected 2", beats); end
      exp_q.delete();
   endtask

   task automatic test_drain_write;
      int beats = 0;
      drive_store(18'h00050, 32'h0000_0011, 3'd3);
      mem_grant = 1'b0;
      push_beats(18'h00050, 32'h0000_0011, 1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (i == 3) begin
            checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL ignore_req_after: got %b expected 0", mem_req); end
         end
         if (mem_req && mem_grant) begin
            beats++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("[TB] FAIL ignore_extra_beat: got %h@%h expected none", mem_dout, mem_addr);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               if ({mem_addr, mem_dout} !== {e.addr, e.data}) begin
                  failures++; $display("[TB] FAIL ignore_beat: got %h@%h expected %h@%h", mem_dout, mem_addr, e.data, e.addr);
               end
            end
         end
         @(posedge clock); #1;
         buffer_write = 1'b0;
         if (i == 0) drive_store(18'h00060, 32'h2222_2222, 3'd4);
         mem_grant = ((i + 1) >= 2);
      end
      checks++; if (beats != 1) begin failures++; $display("[TB] FAIL ignore_count: got %0d expected 1", beats); end
      exp_q.delete();
   endtask

   task automatic test_back_to_back;
      int beats = 0;
      drive_store(18'h00010, 32'h0000_005A, 3'd1);
      mem_grant = 1'b1;
      push_beats(18'h00010, 32'h0000_005A, 1);
      for (int i = 0; i < 7; i++) begin
         @(negedge clock);
         if (i == 2) begin
            checks++; if (buffer_busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_busy_comb: got %b expected 1", buffer_busy); end
         end
         if (mem_req && mem_grant) begin
            beats++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("[TB] FAIL b2b_extra_beat: got %h@%h expected none", mem_dout, mem_addr);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               if ({mem_addr, mem_dout} !== {e.addr, e.data}) begin
                  failures++; $display("[TB] FAIL b2b_beat: got %h@%h expected %h@%h", mem_dout, mem_addr, e.data, e.addr);
               end
            end
         end
         @(posedge clock); #1;
         buffer_write = 1'b0;
         if (i == 1) begin
            checks++; if (buffer_busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_busy_free: got %b expected 0", buffer_busy); end
            drive_store(18'h00020, 32'h0000_BEEF, 3'd2);
            push_beats(18'h00020, 32'h0000_BEEF, 2);
         end
      end
      checks++; if (beats != 3) begin failures++; $display("[TB] FAIL b2b_count: got %0d expected 3", beats); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL b2b_missing: got %0d left expected 0", exp_q.size()); end
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_word(18'h00100, 32'hDDCC_BBAA);
      test_word(18'h3FFFE, 32'h1122_3344);
      test_half();
      test_io();
      test_reset_mid();
      test_drain_write();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
